// File: rtl/uart_rx.sv
// 8N1 UART receiver. Each bit is sampled at its midpoint, and every received
// byte is presented with a one-cycle strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_rdy,
  output logic       o_rx_busy,
  output logic       o_frame_err
);

  localparam logic [13:0] LAST = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF = 14'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic        rx_meta_q, rx_s_q;

  // Both synchronizer flops reset to 1, so a reset looks like an idle line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // A start bit that is already high again at its midpoint is a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            byte_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // o_rx_byte_rdy is a valid-only strobe with no ready: o_rx_byte is valid in that
  // cycle and must be taken then, because the next good byte overwrites it.
  assign o_rx_byte     = byte_q;
  assign o_rx_byte_rdy = rdy_q;
  assign o_rx_busy     = (state_q != IDLE);
  assign o_frame_err   = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: a frame table, then glitch,
// back-to-back, mid-frame reset and a full 0..255 stream.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_rx;
  logic [7:0] o_rx_byte;
  logic       o_rx_byte_rdy;
  logic       o_rx_busy;
  logic       o_frame_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx          (i_rx),
    .o_rx_byte     (o_rx_byte),
    .o_rx_byte_rdy (o_rx_byte_rdy),
    .o_rx_busy     (o_rx_busy),
    .o_frame_err   (o_frame_err)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_rdy;
    logic       exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: all input changes happen on the falling edge.
  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
  endtask

  // Scoreboard: every rdy pulse must match the head of exp_q.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rx_byte_rdy) begin
        rdy_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rdy: got byte %0h with no byte expected", o_rx_byte);
        end else begin
          check("rdy_byte", {24'd0, o_rx_byte}, {24'd0, exp_q.pop_front()});
        end
        check("busy_low_on_rdy", {31'd0, o_rx_busy}, 32'd0);
        check("err_low_on_rdy", {31'd0, o_frame_err}, 32'd0);
      end
      if (o_frame_err) err_cnt++;
    end
  end

  initial begin
    int r0, e0;
    logic [7:0] prev;
    logic saw_busy;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};

    // Reset
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset_byte", {24'd0, o_rx_byte}, 32'd0);
    check("reset_rdy", {31'd0, o_rx_byte_rdy}, 32'd0);
    check("reset_busy", {31'd0, o_rx_busy}, 32'd0);
    check("reset_err", {31'd0, o_frame_err}, 32'd0);
    i_rst_n = 1'b1;
    repeat (CPB) @(negedge i_clk);

    // Frame table
    for (int v = 0; v < 7; v++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      if (vecs[v].exp_rdy) exp_q.push_back(vecs[v].exp_byte);
      send_frame(vecs[v].data, vecs[v].stop);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check($sformatf("vec%0d_rdy_count", v), rdy_cnt - r0, {31'd0, vecs[v].exp_rdy});
      check($sformatf("vec%0d_err_count", v), err_cnt - e0, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_byte", v), {24'd0, o_rx_byte}, {24'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d_idle", v), {31'd0, o_rx_busy}, 32'd0);
    end

    // Glitch: 4 low cycles must not produce a pulse
    prev = o_rx_byte;
    r0 = rdy_cnt;
    e0 = err_cnt;
    saw_busy = 1'b0;
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      if (o_rx_busy) saw_busy = 1'b1;
    end
    check("glitch_busy_rose", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_fell", {31'd0, o_rx_busy}, 32'd0);
    check("glitch_no_rdy", rdy_cnt - r0, 32'd0);
    check("glitch_no_err", err_cnt - e0, 32'd0);
    check("glitch_byte_kept", {24'd0, o_rx_byte}, {24'd0, prev});

    // Back-to-back frames, zero idle gap
    r0 = rdy_cnt;
    e0 = err_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    check("b2b_rdy_count", rdy_cnt - r0, 32'd3);
    check("b2b_err_count", err_cnt - e0, 32'd0);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Reset during data bit 3 of 8'hC3
    r0 = rdy_cnt;
    e0 = err_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_byte", {24'd0, o_rx_byte}, 32'd0);
    check("midrst_rdy", {31'd0, o_rx_byte_rdy}, 32'd0);
    check("midrst_busy", {31'd0, o_rx_busy}, 32'd0);
    check("midrst_err", {31'd0, o_frame_err}, 32'd0);
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("midrst_no_rdy", rdy_cnt - r0, 32'd0);
    check("midrst_no_err", err_cnt - e0, 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    check("postrst_rdy_count", rdy_cnt - r0, 32'd1);
    check("postrst_byte", {24'd0, o_rx_byte}, 32'h12);

    // Stream of bytes 0..255, zero gap
    r0 = rdy_cnt;
    e0 = err_cnt;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("stream_rdy_count", rdy_cnt - r0, 32'd256);
    check("stream_err_count", err_cnt - e0, 32'd0);
    check("stream_queue_empty", exp_q.size(), 32'd0);
    check("stream_last_byte", {24'd0, o_rx_byte}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the block that drives the serial line.
- Consumes an asynchronous 8N1 line (idle high, 1 start, 8 data LSB-first, 1 stop) and presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte consumer (command parser or FIFO).
- Bit timing uses the same CLKS_PER_BIT convention as the transmitter, so a TX/RX pair with equal parameters interoperates.

Parameters:
- CLKS_PER_BIT, 217, i_clk cycles per serial bit; legal range 4..16383; counter is 14 bits wide.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx  input  1  raw serial line, asynchronous to i_clk.
- o_rx_byte  output  8  last correctly received byte; holds until the next good byte.
- o_rx_byte_rdy  output  1  one-cycle pulse; o_rx_byte is valid in the same cycle.
- o_rx_busy  output  1  high whenever the FSM is not IDLE.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Reset (async assert, sync use after deassert):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - o_rx_byte=8'h00; o_rx_byte_rdy=0; o_rx_busy=0; o_frame_err=0.
  - Both synchronizer flops reset to 1, so reset looks like an idle line.
- Input conditioning:
  - i_rx passes through a 2-flop synchronizer; call its output rx_s.
  - All FSM decisions use rx_s only.
  - Latency from pin to rx_s is 2 cycles.
- IDLE:
  - Counter=0, bit index=0.
  - When rx_s=0, go to START with counter=0.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (integer division), which is mid start bit.
  - At mid bit, if rx_s=0: counter=0, go to DATA.
  - At mid bit, if rx_s=1: glitch. Return to IDLE with no output pulse.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift register bit [bit index] and reset the counter.
  - Sampling is LSB first.
  - After bit index 7 is sampled, bit index=0 and go to STOP. Otherwise increment bit index.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - If rx_s=1: o_rx_byte<=shift register, o_rx_byte_rdy=1 for exactly one cycle, go to IDLE.
  - If rx_s=0: o_frame_err=1 for one cycle, o_rx_byte unchanged, no rdy pulse, go to IDLE.
  - Framing-error case: if the line is still low in IDLE, it re-enters START next cycle; this is required behaviour (resync on break).
- Any unencoded state goes to IDLE next cycle.
- Back-to-back frames:
  - The FSM returns to IDLE at mid stop bit, leaving half a bit to detect the next start edge.
  - Continuous frames with zero idle gap must be received without loss.
- Latency: the rdy pulse occurs in the cycle after the stop-bit mid sample.
  - That is about 9.5*CLKS_PER_BIT + 3 cycles after the falling start edge at i_rx.
- o_rx_byte_rdy and o_frame_err are never high in the same cycle.
- Reset mid-frame: all state clears immediately; no rdy or err pulse for the partial frame. The next falling edge after reset release starts a new frame.
- No backpressure: the consumer must take the byte on the rdy cycle. A new byte overwrites the previous one.

Test Plan:
- CLKS_PER_BIT=16: drive 8'hA5 as an 8N1 frame on i_rx -> exactly one o_rx_byte_rdy pulse with o_rx_byte=8'hA5; o_frame_err stays 0; o_rx_busy falls in the rdy cycle.
- Glitch: drive i_rx low for 4 cycles, then high -> o_rx_busy rises, returns low by mid start bit; no rdy or err pulse; o_rx_byte keeps its prior value.
- Framing error: send 8'h3C with the stop bit held low -> one o_frame_err pulse, no rdy pulse, o_rx_byte unchanged; a following valid 8'h55 frame is received correctly.
- Back-to-back: send 8'h00, 8'hFF, 8'h81 with zero idle bits between frames -> three rdy pulses carrying 00, FF, 81 in order.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 of 8'hC3 -> all outputs take reset values asynchronously; no pulse for that frame; a next frame of 8'h12 is received correctly.
- Loopback with the transmitter at equal CLKS_PER_BIT: send bytes 0..255 -> every byte is received in order with no frame errors.
